// File: rtl/muldiv_e_if.sv
// Handshake bundle between the E-stage decode and the mul/div unit.
// start/op/rs_data/rt_data in; busy/hi/lo back out.
interface muldiv_e_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_data, rt_data,
      input  busy, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data,
      output busy, hi, lo
   );
endinterface

// File: rtl/muldiv_e.sv
// E-stage mult/div unit with HI/LO, fixed multi-cycle latency + busy.
// Ports: clk, reset_n (sync, active-low), m (muldiv_e_if.slave).
// Optional madd/maddu: define MD_MADD_EN.
module muldiv_e #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset_n,
   muldiv_e_if.slave m
);
   localparam int MAXL = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW = (MAXL > 1) ? $clog2(MAXL) : 1;
   localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_phi;
   logic [31:0]   r_plo;
   logic          r_wr;

   // op[0]==0 selects the signed flavour for every class
   logic        w_sgn;
   logic [63:0] w_ma;
   logic [63:0] w_mb;
   logic [63:0] w_prod;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic        w_dvz;
   logic [31:0] w_dvs;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_sgn  = ~m.op[0];
   // low 64 bits of the extended product serve both signednesses
   assign w_ma   = {{32{w_sgn & m.rs_data[31]}}, m.rs_data};
   assign w_mb   = {{32{w_sgn & m.rt_data[31]}}, m.rt_data};
   assign w_prod = w_ma * w_mb;

   // magnitude divide, then fix signs; 0x80000000/-1 falls out
   assign w_neg_a = w_sgn & m.rs_data[31];
   assign w_neg_b = w_sgn & m.rt_data[31];
   assign w_abs_a = w_neg_a ? -m.rs_data : m.rs_data;
   assign w_abs_b = w_neg_b ? -m.rt_data : m.rt_data;
   assign w_dvz   = (m.rt_data == 32'd0);
   assign w_dvs   = w_dvz ? 32'd1 : w_abs_b;
   assign w_uq    = w_abs_a / w_dvs;
   assign w_ur    = w_abs_a % w_dvs;
   assign w_quo   = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
   assign w_rem   = w_neg_a ? -w_ur : w_ur;

`ifdef MD_MADD_EN
   logic [63:0] w_acc;
   assign w_acc = {r_hi, r_lo} + w_prod;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_phi   <= '0;
         r_plo   <= '0;
         r_wr    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (m.start) begin
                  unique case (m.op)
                     3'b000, 3'b001: begin
                        r_phi   <= w_prod[63:32];
                        r_plo   <= w_prod[31:0];
                        r_wr    <= 1'b1;
                        r_cnt   <= MUL_LD;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                     end
                     3'b010, 3'b011: begin
                        r_phi   <= w_rem;
                        r_plo   <= w_quo;
                        // divide by zero runs but never writes
                        r_wr    <= ~w_dvz;
                        r_cnt   <= DIV_LD;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                     end
                     3'b100: r_hi <= m.rs_data;
                     3'b101: r_lo <= m.rs_data;
                     3'b110, 3'b111: begin
`ifdef MD_MADD_EN
                        r_phi   <= w_acc[63:32];
                        r_plo   <= w_acc[31:0];
                        r_wr    <= 1'b1;
                        r_cnt   <= MUL_LD;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`else
                        r_state <= S_IDLE;
`endif
                     end
                  endcase
               end
            end
            S_RUN: begin
               if (r_cnt == '0) begin
                  if (r_wr) begin
                     r_hi <= r_phi;
                     r_lo <= r_plo;
                  end
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   assign m.busy = r_busy;
   assign m.hi   = r_hi;
   assign m.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_e.sv
// Self-checking bench for muldiv_e: directed table, corner
// sequences and random ops against a longint reference model.
module tb_muldiv_e;
   localparam int ML = 5;
   localparam int DL = 10;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_e_if u_if ();

   muldiv_e #(
      .MULT_CYCLES(ML),
      .DIV_CYCLES (DL)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .m      (u_if)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          elat;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: plain 64-bit arithmetic on the architectural rules
   function automatic int model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      int lat;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lat = 0;
      case (op)
         3'd0: begin p = sa * sb; {m_hi, m_lo} = p; lat = ML; end
         3'd1: begin
            p = {32'h0, a} * {32'h0, b};
            {m_hi, m_lo} = p;
            lat = ML;
         end
         3'd2: begin
            lat = DL;
            if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               m_lo = q[31:0];
               m_hi = r[31:0];
            end
         end
         3'd3: begin
            lat = DL;
            if (b != 0) begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: begin
`ifdef MD_MADD_EN
            p = (op == 3'd6) ? sa * sb : {32'h0, a} * {32'h0, b};
            {m_hi, m_lo} = {m_hi, m_lo} + p;
            lat = ML;
`else
            lat = 0;
`endif
         end
      endcase
      return lat;
   endfunction

   task automatic run_op(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] old_hi,
                         input logic [31:0] old_lo,
                         output int lat,
                         output bit stable);
      lat = 0;
      stable = 1'b1;
      @(negedge clk);
      u_if.start   = 1'b1;
      u_if.op      = op;
      u_if.rs_data = a;
      u_if.rt_data = b;
      @(negedge clk);
      u_if.start = 1'b0;
      while (u_if.busy === 1'b1 && lat < 100) begin
         lat++;
         if (u_if.hi !== old_hi || u_if.lo !== old_lo) stable = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit stable;
      int cnt;
      int elat;
      logic [2:0]  op;
      logic [31:0] a, b, oh, ol, eh, el;

      u_if.start   = 1'b0;
      u_if.op      = 3'd0;
      u_if.rs_data = '0;
      u_if.rt_data = '0;
      reset_n      = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", {31'b0, u_if.busy}, 32'd0);
      chk("reset hi", u_if.hi, 32'd0);
      chk("reset lo", u_if.lo, 32'd0);
      reset_n = 1'b1;

      tbl[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,
                  32'hFFFFFFFF, 32'hFFFFFFFA, ML};
      tbl[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,
                  32'h2, 32'hFFFFFFFA, ML};
      tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFF, 32'hFFFFFFFD, DL};
      tbl[3]  = '{3'd3, 32'd7, 32'd2, 32'd1, 32'd3, DL};
      tbl[4]  = '{3'd4, 32'h11, 32'd0, 32'h11, 32'd3, 0};
      tbl[5]  = '{3'd5, 32'h22, 32'd0, 32'h11, 32'h22, 0};
      tbl[6]  = '{3'd2, 32'd5, 32'd0, 32'h11, 32'h22, DL};
      tbl[7]  = '{3'd4, 32'hDEADBEEF, 32'd0,
                  32'hDEADBEEF, 32'h22, 0};
      tbl[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF,
                  32'h0, 32'h80000000, DL};
      tbl[9]  = '{3'd4, 32'h0, 32'd0, 32'h0, 32'h80000000, 0};
      tbl[10] = '{3'd5, 32'hFFFFFFFF, 32'd0,
                  32'h0, 32'hFFFFFFFF, 0};
`ifdef MD_MADD_EN
      tbl[11] = '{3'd6, 32'd1, 32'd1, 32'h1, 32'h0, ML};
`else
      tbl[11] = '{3'd6, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0};
`endif

      eh = '0;
      el = '0;
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, eh, el, lat, stable);
         chk($sformatf("t%0d lat", i), 32'(lat), 32'(tbl[i].elat));
         if (lat > 0)
            chk($sformatf("t%0d hold", i), {31'b0, stable}, 32'd1);
         chk($sformatf("t%0d hi", i), u_if.hi, tbl[i].ehi);
         chk($sformatf("t%0d lo", i), u_if.lo, tbl[i].elo);
         eh = tbl[i].ehi;
         el = tbl[i].elo;
      end

      // start while busy: mult then mthi must both be dropped
      @(negedge clk);
      u_if.start   = 1'b1;
      u_if.op      = 3'd0;
      u_if.rs_data = 32'd6;
      u_if.rt_data = 32'd7;
      @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (u_if.busy === 1'b1) cnt++;
         case (k)
            0: begin
               u_if.start   = 1'b1;
               u_if.op      = 3'd0;
               u_if.rs_data = 32'd100;
               u_if.rt_data = 32'd100;
            end
            1: begin
               u_if.start   = 1'b1;
               u_if.op      = 3'd4;
               u_if.rs_data = 32'h999;
            end
            default: u_if.start = 1'b0;
         endcase
         @(negedge clk);
      end
      chk("busy-start lat", 32'(cnt), 32'(ML));
      chk("busy-start hi", u_if.hi, 32'd0);
      chk("busy-start lo", u_if.lo, 32'd42);
      chk("busy-start idle", {31'b0, u_if.busy}, 32'd0);

      // reset in the middle of a divide
      run_op(3'd4, 32'h77, 32'd0, 32'd0, 32'd42, lat, stable);
      chk("pre-rst hi", u_if.hi, 32'h77);
      @(negedge clk);
      u_if.start   = 1'b1;
      u_if.op      = 3'd3;
      u_if.rs_data = 32'd100;
      u_if.rt_data = 32'd7;
      @(negedge clk);
      u_if.start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid-rst busy", {31'b0, u_if.busy}, 32'd0);
      chk("mid-rst hi", u_if.hi, 32'd0);
      chk("mid-rst lo", u_if.lo, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("post-rst busy", {31'b0, u_if.busy}, 32'd0);
      chk("post-rst hi", u_if.hi, 32'd0);
      chk("post-rst lo", u_if.lo, 32'd0);
      m_hi = '0;
      m_lo = '0;

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 20));
            2: b = -32'($urandom_range(1, 20));
            3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            default: ;
         endcase
         oh = m_hi;
         ol = m_lo;
         elat = model(op, a, b);
         run_op(op, a, b, oh, ol, lat, stable);
         chk($sformatf("r%0d op%0d lat", i, op), 32'(lat), 32'(elat));
         if (lat > 0)
            chk($sformatf("r%0d hold", i), {31'b0, stable}, 32'd1);
         chk($sformatf("r%0d op%0d hi", i, op), u_if.hi, m_hi);
         chk($sformatf("r%0d op%0d lo", i, op), u_if.lo, m_lo);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule
